exec_controller: RTL and testbench
==================================

// Module: exec_controller
// PURPOSE
//  Run/step sequencer for the 16-bit CPU core. Gates per-instruction execution with one
//  enable (cpu_en) feeding the IP register and regfile write enable. Counts retired
//  instructions and halts on stop command, IP outside ROM, or instruction budget.
//  Sits between the test harness (start/stop/step) and the datapath, replacing ad-hoc bench checks.
// PARAMETERS
//  ADDR_SIZE  16   width of ip input (matches InstructionPointer addr_size)
//  ROM_SIZE   256  number of ROM words; ip >= ROM_SIZE is out of range
//  CNT_W      32   width of instruction counter and budget
// PORTS
//  clk         in   1          system clock, all state updates on rising edge
//  rst         in   1          synchronous reset, active-high
//  start       in   1          level-sampled: enter/resume RUN
//  stop        in   1          level-sampled: halt with code STOP
//  clear       in   1          leave HALT, return to IDLE, zero counter
//  step_req    in   1          4-phase single-step request
//  step_ack    out  1          4-phase single-step acknowledge
//  max_instr   in   CNT_W      instruction budget; 0 = unlimited
//  ip          in   ADDR_SIZE  current instruction pointer from datapath
//  cpu_en      out  1          execute/retire current instruction this cycle
//  running     out  1          high in RUN
//  halted      out  1          high in HALT
//  halt_code   out  3          0 NONE, 1 STOP, 2 IP_RANGE, 3 BUDGET, 4 BREAKPOINT
//  instr_count out  CNT_W      retired instruction count
// BEHAVIOUR
//  Reset: state IDLE; cpu_en=0, step_ack=0, running=0, halted=0, halt_code=0, instr_count=0.
//  States IDLE, RUN, STEP_EXEC, STEP_ACK, HALT; state registered, cpu_en combinational from state.
//  halt_cond (combinational) = ip >= ROM_SIZE (IP_RANGE) or (max_instr!=0 && instr_count>=max_instr) (BUDGET);
//   IP_RANGE has priority over BUDGET.
//  IDLE: stop ignored; start -> RUN; else step_req -> STEP_EXEC; start wins over step_req.
//  RUN: cpu_en = !halt_cond && !stop. stop -> HALT/STOP (no cpu_en that cycle);
//   halt_cond -> HALT with its code. stop has priority over halt_cond; start ignored; step_req ignored.
//  STEP_EXEC: lasts exactly one cycle; cpu_en=!halt_cond; -> STEP_ACK, or HALT with code if halt_cond.
//  STEP_ACK: step_ack=1; step_req low -> IDLE. HALT: step_ack=step_req, so a pending step always completes.
//  HALT: halted=1, halt_code held. clear -> IDLE, instr_count=0, halt_code=0.
//   start -> RUN only if halt_code is STOP or BREAKPOINT (code -> 0); IP_RANGE/BUDGET sticky until clear.
//   clear has priority over start.
//  Latency: start sampled high at edge N -> running and first cpu_en during cycle N..N+1.
//  instr_count increments on every cycle with cpu_en=1; saturates at 2**CNT_W-1, never wraps.
//  Budget compare is unsigned; changing max_instr mid-run takes effect next cycle.
//  rst mid-operation: immediate return to reset values on next edge, any step handshake aborted.
// CONFIGURATION
//  EXEC_BREAKPOINT_EN defined: adds ports bp_valid (in,1) and bp_addr (in,ADDR_SIZE).
//   In RUN, bp_valid && ip==bp_addr -> HALT/BREAKPOINT before that instruction executes (no cpu_en);
//   priority: stop > IP_RANGE > BUDGET > BREAKPOINT. On resume via start, the first RUN cycle skips
//   the breakpoint check so execution continues past it. STEP_EXEC never checks breakpoints.
//  Not defined: ports absent, code 4 never produced.
// TESTING
//  1 Reset, max_instr=0, ip held 5, start 1 cycle -> cpu_en every cycle, count 10 after 10 cycles, halted=0.
//  2 max_instr=3, start -> exactly 3 cpu_en pulses, then halted=1, halt_code=3; start ignored; clear -> IDLE, count=0.
//  3 RUN, ip driven to 256 -> same cycle cpu_en=0, next HALT code 2; ip=255 still executes.
//  4 step_req high in IDLE -> one cpu_en pulse, step_ack high until step_req low, then IDLE; count=1.
//  5 stop+start same cycle in RUN -> HALT code 1; start next -> RUN resumes, count continues.
//  6 EXEC_BREAKPOINT_EN, bp_addr=7, ip ramps 0..9 -> halt code 4 at ip=7 with count 7; start -> ip 7 executes.

Source files
------------

// File: rtl/exec_controller.sv
// exec_controller: run/step sequencer for the 16-bit CPU core.
// Produces a single execute enable (cpu_en) for the IP register and the regfile
// write enable. Counts retired instructions and halts on stop, IP outside the ROM,
// or an exhausted instruction budget.
// Optional feature: define EXEC_BREAKPOINT_EN to add a single address breakpoint
// (ports bp_valid, bp_addr; halt code BREAKPOINT).
module exec_controller #(
  parameter int ADDR_SIZE = 16,
  parameter int ROM_SIZE  = 256,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 step_req,
  output logic                 step_ack,
  input  logic [CNT_W-1:0]     max_instr,
  input  logic [ADDR_SIZE-1:0] ip,
`ifdef EXEC_BREAKPOINT_EN
  input  logic                 bp_valid,
  input  logic [ADDR_SIZE-1:0] bp_addr,
`endif
  output logic                 cpu_en,
  output logic                 running,
  output logic                 halted,
  output logic [2:0]           halt_code,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_EXEC,
    S_STEP_ACK,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    HC_NONE       = 3'd0,
    HC_STOP       = 3'd1,
    HC_IP_RANGE   = 3'd2,
    HC_BUDGET     = 3'd3,
    HC_BREAKPOINT = 3'd4
  } halt_code_e;

  // One extra bit so a ROM_SIZE equal to 2**ADDR_SIZE still compares correctly.
  localparam logic [ADDR_SIZE:0] ROM_LIMIT = (ADDR_SIZE+1)'(ROM_SIZE);

  state_e          state_q, state_d;
  halt_code_e      code_q, code_d;
  logic            cnt_clear;
  logic            ip_range;
  logic            budget_hit;
  logic            halt_cond;
  halt_code_e      cond_code;
  logic            bp_hit;

  // Halt conditions seen by the current instruction; IP_RANGE outranks BUDGET.
  always_comb begin
    ip_range   = ({1'b0, ip} >= ROM_LIMIT);
    budget_hit = (max_instr != '0) && (instr_count >= max_instr);
    halt_cond  = ip_range || budget_hit;
    cond_code  = ip_range ? HC_IP_RANGE : HC_BUDGET;
  end

`ifdef EXEC_BREAKPOINT_EN
  // Set for exactly the first RUN cycle after a resume, so execution moves past
  // the breakpoint that caused the halt.
  logic skip_bp_q, skip_bp_d;

  // Breakpoint match, suppressed on the resume cycle.
  always_comb begin
    bp_hit = bp_valid && (ip == bp_addr) && !skip_bp_q;
  end
`else
  // Breakpoints not built: never matches.
  always_comb begin
    bp_hit = 1'b0;
  end
`endif

  // Next-state and combinational outputs of the sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    code_d    = code_q;
    cnt_clear = 1'b0;
    cpu_en    = 1'b0;
    step_ack  = 1'b0;
`ifdef EXEC_BREAKPOINT_EN
    skip_bp_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start)         state_d = S_RUN;
        else if (step_req) state_d = S_STEP_EXEC;
      end
      S_RUN: begin
        cpu_en = !halt_cond && !stop && !bp_hit;
        if (stop) begin
          state_d = S_HALT;
          code_d  = HC_STOP;
        end else if (halt_cond) begin
          state_d = S_HALT;
          code_d  = cond_code;
        end else if (bp_hit) begin
          state_d = S_HALT;
          code_d  = HC_BREAKPOINT;
        end
      end
      S_STEP_EXEC: begin
        cpu_en = !halt_cond;
        if (halt_cond) begin
          state_d = S_HALT;
          code_d  = cond_code;
        end else begin
          state_d = S_STEP_ACK;
        end
      end
      S_STEP_ACK: begin
        step_ack = 1'b1;
        if (!step_req) state_d = S_IDLE;
      end
      S_HALT: begin
        // Echo the request so a step that ran into a halt still completes.
        step_ack = step_req;
        if (clear) begin
          state_d   = S_IDLE;
          code_d    = HC_NONE;
          cnt_clear = 1'b1;
        end else if (start && (code_q == HC_STOP || code_q == HC_BREAKPOINT)) begin
          state_d = S_RUN;
          code_d  = HC_NONE;
`ifdef EXEC_BREAKPOINT_EN
          skip_bp_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and halt code registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= HC_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

`ifdef EXEC_BREAKPOINT_EN
  // Resume marker for the breakpoint skip.
  always_ff @(posedge clk) begin
    if (rst) skip_bp_q <= 1'b0;
    else     skip_bp_q <= skip_bp_d;
  end
`endif

  // Retired instruction counter; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear)                 instr_count <= '0;
    else if (cpu_en && instr_count != '1) instr_count <= instr_count + 1'b1;
  end

  assign running   = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign halt_code = code_q;

endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: directed scoreboard bench for exec_controller.
// Stimulus pushes expected (field, value) pairs for the current cycle; a monitor
// pops and compares them on the falling edge. Define EXEC_BREAKPOINT_EN to also
// exercise the breakpoint feature.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, step_req;
  logic        step_ack, cpu_en, running, halted;
  logic [31:0] max_instr;
  logic [15:0] ip;
  logic [2:0]  halt_code;
  logic [31:0] instr_count;
`ifdef EXEC_BREAKPOINT_EN
  logic        bp_valid;
  logic [15:0] bp_addr;
`endif

  exec_controller #(.ADDR_SIZE(16), .ROM_SIZE(256), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .step_req(step_req), .step_ack(step_ack), .max_instr(max_instr), .ip(ip),
`ifdef EXEC_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr),
`endif
    .cpu_en(cpu_en), .running(running), .halted(halted),
    .halt_code(halt_code), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum {F_CPU_EN, F_RUNNING, F_HALTED, F_CODE, F_COUNT, F_ACK} field_e;
  typedef struct {
    string       tag;
    field_e      f;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, req);
    end
  endtask

  task automatic expect_v(input string tag, input field_e f, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.f)
        F_CPU_EN:  act = {31'd0, cpu_en};
        F_RUNNING: act = {31'd0, running};
        F_HALTED:  act = {31'd0, halted};
        F_CODE:    act = {29'd0, halt_code};
        F_COUNT:   act = instr_count;
        default:   act = {31'd0, step_ack};
      endcase
      check(e.tag, act, e.val);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; step_req = 1'b0;
    max_instr = 32'd0; ip = 16'd5;
`ifdef EXEC_BREAKPOINT_EN
    bp_valid = 1'b0; bp_addr = 16'd0;
`endif
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values.
    do_reset();
    expect_v("rst_cpu_en", F_CPU_EN, 0);
    expect_v("rst_running", F_RUNNING, 0);
    expect_v("rst_halted", F_HALTED, 0);
    expect_v("rst_code", F_CODE, 0);
    expect_v("rst_count", F_COUNT, 0);
    expect_v("rst_ack", F_ACK, 0);

    // 1: unlimited run, ip held at 5.
    start = 1'b1;
    expect_v("t1_idle_no_en", F_CPU_EN, 0);
    cyc();
    start = 1'b0;
    expect_v("t1_running", F_RUNNING, 1);
    for (int i = 0; i < 10; i++) begin
      expect_v("t1_en", F_CPU_EN, 1);
      expect_v("t1_cnt", F_COUNT, 32'(i));
      cyc();
    end
    expect_v("t1_count10", F_COUNT, 10);
    expect_v("t1_not_halted", F_HALTED, 0);
    stop = 1'b1;
    expect_v("t1_stop_no_en", F_CPU_EN, 0);
    cyc();
    stop = 1'b0;
    expect_v("t1_halted", F_HALTED, 1);
    expect_v("t1_code_stop", F_CODE, 1);
    expect_v("t1_count_kept", F_COUNT, 10);

    // 2: budget of 3.
    do_reset();
    max_instr = 32'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_v("t2_en", F_CPU_EN, 1);
      expect_v("t2_cnt", F_COUNT, 32'(i));
      cyc();
    end
    expect_v("t2_budget_no_en", F_CPU_EN, 0);
    expect_v("t2_still_run", F_RUNNING, 1);
    cyc();
    expect_v("t2_halted", F_HALTED, 1);
    expect_v("t2_code_budget", F_CODE, 3);
    expect_v("t2_count3", F_COUNT, 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_v("t2_sticky_halted", F_HALTED, 1);
    expect_v("t2_sticky_code", F_CODE, 3);
    expect_v("t2_sticky_no_en", F_CPU_EN, 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    expect_v("t2_clr_halted", F_HALTED, 0);
    expect_v("t2_clr_running", F_RUNNING, 0);
    expect_v("t2_clr_code", F_CODE, 0);
    expect_v("t2_clr_count", F_COUNT, 0);

    // 3: ip leaves the ROM.
    do_reset();
    ip = 16'd254;
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_v("t3_en_254", F_CPU_EN, 1);
    cyc();
    ip = 16'd255;
    expect_v("t3_en_255", F_CPU_EN, 1);
    expect_v("t3_cnt_255", F_COUNT, 1);
    cyc();
    ip = 16'd256;
    expect_v("t3_no_en_256", F_CPU_EN, 0);
    expect_v("t3_run_256", F_RUNNING, 1);
    cyc();
    expect_v("t3_halted", F_HALTED, 1);
    expect_v("t3_code_range", F_CODE, 2);
    expect_v("t3_count2", F_COUNT, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_v("t3_sticky_code", F_CODE, 2);
    expect_v("t3_sticky_running", F_RUNNING, 0);

    // 4: single step handshake.
    do_reset();
    step_req = 1'b1;
    expect_v("t4_idle_no_en", F_CPU_EN, 0);
    cyc();
    expect_v("t4_exec_en", F_CPU_EN, 1);
    expect_v("t4_exec_no_ack", F_ACK, 0);
    cyc();
    expect_v("t4_ack", F_ACK, 1);
    expect_v("t4_ack_no_en", F_CPU_EN, 0);
    expect_v("t4_count1", F_COUNT, 1);
    cyc();
    expect_v("t4_ack_hold", F_ACK, 1);
    step_req = 1'b0;
    expect_v("t4_ack_until_drop", F_ACK, 1);
    cyc();
    expect_v("t4_idle_ack", F_ACK, 0);
    expect_v("t4_idle_no_en2", F_CPU_EN, 0);
    expect_v("t4_idle_count", F_COUNT, 1);
    expect_v("t4_idle_running", F_RUNNING, 0);

    // 5: stop and start together, then resume.
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    stop = 1'b1;
    start = 1'b1;
    expect_v("t5_stop_no_en", F_CPU_EN, 0);
    expect_v("t5_cnt_before", F_COUNT, 2);
    cyc();
    stop = 1'b0;
    expect_v("t5_halted", F_HALTED, 1);
    expect_v("t5_code_stop", F_CODE, 1);
    cyc();
    start = 1'b0;
    expect_v("t5_resumed", F_RUNNING, 1);
    expect_v("t5_code_cleared", F_CODE, 0);
    expect_v("t5_resume_en", F_CPU_EN, 1);
    expect_v("t5_resume_cnt", F_COUNT, 2);
    cyc();
    expect_v("t5_cnt_continues", F_COUNT, 3);

`ifdef EXEC_BREAKPOINT_EN
    // 6: breakpoint at 7 with ip following the retired count.
    do_reset();
    bp_valid = 1'b1;
    bp_addr  = 16'd7;
    ip       = 16'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ip = 16'(i);
      expect_v("t6_en", F_CPU_EN, 1);
      cyc();
    end
    ip = 16'd7;
    expect_v("t6_bp_no_en", F_CPU_EN, 0);
    expect_v("t6_bp_count", F_COUNT, 7);
    cyc();
    expect_v("t6_halted", F_HALTED, 1);
    expect_v("t6_code_bp", F_CODE, 4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    expect_v("t6_resume_en_ip7", F_CPU_EN, 1);
    expect_v("t6_resume_code", F_CODE, 0);
    cyc();
    ip = 16'd8;
    expect_v("t6_en_ip8", F_CPU_EN, 1);
    expect_v("t6_cnt8", F_COUNT, 8);
`endif

    cyc();
    cyc();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
